// File: rtl/shift_reg_piso_stream.sv
// Parallel-in/serial-out shifter: loads a W-bit word, emits LANES bits per beat, back-fills with FILL.
// First beat one cycle after load; ser_ready low stalls in place; reload allowed on the last beat.
module shift_reg_piso_stream #(
  parameter int   W         = 8,
  parameter int   LANES     = 1,
  parameter bit   MSB_FIRST = 1'b0,
  parameter logic FILL      = 1'b1,
  parameter int   CW        = $clog2(W/LANES+1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [W-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             abort,
  output logic [LANES-1:0] ser_data,
  output logic             ser_valid,
  input  logic             ser_ready,
  output logic             ser_last,
  output logic             busy,
  output logic             done,
  output logic [CW-1:0]    remaining
);

  localparam int N = W / LANES;

  if (W < LANES || (W % LANES) != 0) begin : g_bad_params
    $error("shift_reg_piso_stream: W must be a non-zero multiple of LANES");
  end

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t          state_q, state_nxt;
  logic [W-1:0]    shift_q, shift_nxt, shifted;
  logic [CW-1:0]   count_q, count_nxt;
  logic            done_q, done_nxt;
  logic            load, beat;

  // With a single beat per word every bit is vacated at once.
  if (W == LANES) begin : g_single
    assign shifted = {W{FILL}};
  end else if (MSB_FIRST) begin : g_left
    assign shifted = {shift_q[W-1-LANES:0], {LANES{FILL}}};
  end else begin : g_right
    assign shifted = {{LANES{FILL}}, shift_q[W-1:LANES]};
  end

  assign ser_valid = (state_q == SHIFT);
  assign busy      = (state_q == SHIFT);
  assign ser_last  = (state_q == SHIFT) && (count_q == CW'(1));
  assign remaining = count_q;
  assign done      = done_q;
  assign ser_data  = MSB_FIRST ? shift_q[W-1 -: LANES] : shift_q[LANES-1:0];
  assign in_ready  = ~abort & ((state_q == IDLE) | (ser_last & ser_ready));
  assign load      = in_valid & in_ready;
  assign beat      = ser_valid & ser_ready;

  always_comb begin
    state_nxt = state_q;
    shift_nxt = shift_q;
    count_nxt = count_q;
    done_nxt  = 1'b0;
    if (abort) begin
      state_nxt = IDLE;
      shift_nxt = '0;
      count_nxt = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load) begin
            shift_nxt = in_data;
            count_nxt = CW'(N);
            state_nxt = SHIFT;
          end
        end
        SHIFT: begin
          if (beat) begin
            if (count_q == CW'(1)) begin
              done_nxt = 1'b1;
              if (load) begin
                shift_nxt = in_data;
                count_nxt = CW'(N);
              end else begin
                shift_nxt = shifted;
                count_nxt = '0;
                state_nxt = IDLE;
              end
            end else begin
              shift_nxt = shifted;
              count_nxt = count_q - CW'(1);
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      count_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      shift_q <= shift_nxt;
      count_q <= count_nxt;
      done_q  <= done_nxt;
    end
  end

endmodule

// File: tb/tb_shift_reg_piso_stream.sv
// Scoreboard bench for three shifter configurations: (8,1,LSB), (8,2,MSB), (4,4,LSB).
module tb_shift_reg_piso_stream;

  localparam int WP [3] = '{8, 8, 4};
  localparam int LP [3] = '{1, 2, 4};
  localparam int MP [3] = '{0, 1, 0};

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] id_a [3];
  logic       iv_a [3];
  logic       ab_a [3];
  logic       sr_a [3];
  logic       rdy_a [3];
  logic       sv_a [3];
  logic       sl_a [3];
  logic       bz_a [3];
  logic       dn_a [3];
  logic [3:0] sd_a [3];
  logic [3:0] rem_a [3];

  logic [0:0] sd0;
  logic [1:0] sd1;
  logic [3:0] sd2;
  logic [3:0] rem0;
  logic [2:0] rem1;
  logic [0:0] rem2;

  int n_chk = 0;
  int n_fail = 0;

  logic [3:0] exp_d [3][64];
  logic       exp_l [3][64];
  int         hd [3];
  int         tl [3];
  logic       done_exp [3];

  always #5 clk = ~clk;

  shift_reg_piso_stream #(.W(8), .LANES(1), .MSB_FIRST(1'b0)) u0 (
    .clk(clk), .reset(rst), .in_data(id_a[0]), .in_valid(iv_a[0]), .in_ready(rdy_a[0]),
    .abort(ab_a[0]), .ser_data(sd0), .ser_valid(sv_a[0]), .ser_ready(sr_a[0]),
    .ser_last(sl_a[0]), .busy(bz_a[0]), .done(dn_a[0]), .remaining(rem0));

  shift_reg_piso_stream #(.W(8), .LANES(2), .MSB_FIRST(1'b1)) u1 (
    .clk(clk), .reset(rst), .in_data(id_a[1]), .in_valid(iv_a[1]), .in_ready(rdy_a[1]),
    .abort(ab_a[1]), .ser_data(sd1), .ser_valid(sv_a[1]), .ser_ready(sr_a[1]),
    .ser_last(sl_a[1]), .busy(bz_a[1]), .done(dn_a[1]), .remaining(rem1));

  shift_reg_piso_stream #(.W(4), .LANES(4), .MSB_FIRST(1'b0)) u2 (
    .clk(clk), .reset(rst), .in_data(id_a[2][3:0]), .in_valid(iv_a[2]), .in_ready(rdy_a[2]),
    .abort(ab_a[2]), .ser_data(sd2), .ser_valid(sv_a[2]), .ser_ready(sr_a[2]),
    .ser_last(sl_a[2]), .busy(bz_a[2]), .done(dn_a[2]), .remaining(rem2));

  assign sd_a[0]  = {3'b000, sd0};
  assign sd_a[1]  = {2'b00, sd1};
  assign sd_a[2]  = sd2;
  assign rem_a[0] = rem0;
  assign rem_a[1] = {1'b0, rem1};
  assign rem_a[2] = {3'b000, rem2};

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s u%0d: got %0h expected %0h at %0t", nm, inst, act, exp, $time);
    end
  endtask

  // Beat k of a word is simply the k-th LANES-wide slice counted from the chosen end.
  function automatic logic [3:0] beat_of(input int i, input logic [7:0] d, input int k);
    int sh;
    logic [7:0] m;
    sh = (MP[i] != 0) ? WP[i] - (k + 1) * LP[i] : k * LP[i];
    m  = 8'((1 << LP[i]) - 1);
    return 4'((d >> sh) & m);
  endfunction

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      automatic int         cnt;
      automatic logic       lst;
      automatic logic [3:0] dat;
      automatic logic       exp_rdy;
      if (rst) begin
        chk("rst_ser_valid", i, 32'(sv_a[i]), 0);
        chk("rst_busy", i, 32'(bz_a[i]), 0);
        chk("rst_remaining", i, 32'(rem_a[i]), 0);
        chk("rst_done", i, 32'(dn_a[i]), 0);
        chk("rst_ser_last", i, 32'(sl_a[i]), 0);
        chk("rst_ser_data", i, 32'(sd_a[i]), 0);
        chk("rst_in_ready", i, 32'(rdy_a[i]), 32'(!ab_a[i]));
        hd[i] = 0;
        tl[i] = 0;
        done_exp[i] = 1'b0;
      end else begin
        cnt = tl[i] - hd[i];
        lst = (cnt > 0) ? exp_l[i][hd[i] % 64] : 1'b0;
        dat = (cnt > 0) ? exp_d[i][hd[i] % 64] : 4'h0;
        chk("ser_valid", i, 32'(sv_a[i]), 32'(cnt > 0));
        chk("busy", i, 32'(bz_a[i]), 32'(cnt > 0));
        chk("remaining", i, 32'(rem_a[i]), 32'(cnt));
        chk("ser_last", i, 32'(sl_a[i]), 32'(lst));
        chk("done", i, 32'(dn_a[i]), 32'(done_exp[i]));
        if (cnt > 0) chk("ser_data", i, 32'(sd_a[i]), 32'(dat));
        exp_rdy = !ab_a[i] && (cnt == 0 || (cnt == 1 && sr_a[i]));
        chk("in_ready", i, 32'(rdy_a[i]), 32'(exp_rdy));
        done_exp[i] = 1'b0;
        if (ab_a[i]) begin
          hd[i] = tl[i];
        end else begin
          if (cnt > 0 && sr_a[i]) begin
            hd[i]++;
            if (lst) done_exp[i] = 1'b1;
          end
          if (exp_rdy && iv_a[i]) begin
            for (int k = 0; k < WP[i] / LP[i]; k++) begin
              exp_d[i][tl[i] % 64] = beat_of(i, id_a[i], k);
              exp_l[i][tl[i] % 64] = (k == WP[i] / LP[i] - 1);
              tl[i]++;
            end
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int i, input logic [7:0] d);
    iv_a[i] = 1'b1;
    id_a[i] = d;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (rdy_a[i]) begin
        @(posedge clk);
        #1;
        iv_a[i] = 1'b0;
        return;
      end
    end
    n_chk++;
    n_fail++;
    $display("FAIL send_timeout u%0d: in_ready never seen, required 1", i);
    iv_a[i] = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      id_a[i] = 8'h00;
      iv_a[i] = 1'b0;
      ab_a[i] = 1'b0;
      sr_a[i] = 1'b1;
    end
    cyc(3);
    rst = 1'b0;
    cyc(2);

    send(0, 8'hA5);
    cyc(12);

    send(1, 8'hB4);
    cyc(1);
    sr_a[1] = 1'b0;
    cyc(3);
    sr_a[1] = 1'b1;
    cyc(6);

    send(0, 8'h0F);
    send(0, 8'hF0);
    cyc(10);

    send(0, 8'hA5);
    cyc(2);
    ab_a[0] = 1'b1;
    iv_a[0] = 1'b1;
    id_a[0] = 8'h3C;
    cyc(1);
    ab_a[0] = 1'b0;
    iv_a[0] = 1'b0;
    cyc(1);
    send(0, 8'h3C);
    cyc(10);

    send(0, 8'hA5);
    cyc(2);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", 0, 32'(sv_a[0]), 0);
    chk("async_rst_remaining", 0, 32'(rem_a[0]), 0);
    chk("async_rst_done", 0, 32'(dn_a[0]), 0);
    chk("async_rst_in_ready", 0, 32'(rdy_a[0]), 1);
    @(posedge clk);
    #2;
    rst = 1'b0;
    cyc(1);
    send(0, 8'h01);
    cyc(12);

    send(2, 8'h01);
    send(2, 8'h02);
    send(2, 8'h03);
    cyc(4);

    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 3; i++) begin
        iv_a[i] = ($urandom_range(0, 3) != 0);
        id_a[i] = 8'($urandom);
        sr_a[i] = ($urandom_range(0, 3) != 0);
        ab_a[i] = ($urandom_range(0, 39) == 0);
      end
      cyc(1);
    end
    for (int i = 0; i < 3; i++) begin
      iv_a[i] = 1'b0;
      ab_a[i] = 1'b0;
      sr_a[i] = 1'b1;
    end
    cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_reg_piso_stream.md
Name: shift_reg_piso_stream

Overview:
Parametrised parallel-in/serial-out shifter with valid/ready handshakes on both sides. It accepts a W-bit word, emits it LANES bits per beat in a configurable order, and back-fills vacated bits with a fixed FILL value. It provides beat counting, a last-beat marker, a done pulse, abort, and back-to-back word reload. It is the successor to the single-lane set/shift shift register and sits between word-wide producers and serial link or encoder logic.

Parameters:
W, 8, word width in bits; must satisfy W >= LANES and W % LANES == 0 (elaboration-time check, $error otherwise).
LANES, 1, bits emitted per beat; N = W/LANES beats per word.
MSB_FIRST, 0, 0 = LSB-side first with right shift; 1 = MSB-side first with left shift.
FILL, 1'b1, value shifted into vacated bit positions.
CW, $clog2(W/LANES+1), width of the remaining counter (derived; not overridden).

Ports:
clk  in  1  rising-edge clock.
reset  in  1  asynchronous, active-high; clears all state.
in_data  in  W  parallel word; sampled when in_valid & in_ready.
in_valid  in  1  producer has a word.
in_ready  out  1  block can accept a word this cycle.
abort  in  1  synchronous flush; highest priority after reset.
ser_data  out  LANES  current beat.
ser_valid  out  1  ser_data is valid.
ser_ready  in  1  consumer accepts the beat.
ser_last  out  1  current beat is beat N of the word.
busy  out  1  a word is in flight (state SHIFT).
done  out  1  one-cycle pulse after the last beat is accepted.
remaining  out  CW  beats not yet accepted for the current word; 0 in IDLE.

Behaviour:
- Reset (asynchronous, active-high): state = IDLE, register = 0, count = 0, done = 0. Outputs: in_ready = 1, ser_valid = 0, ser_last = 0, busy = 0, remaining = 0, ser_data = 0.
- States are IDLE and SHIFT.
- ser_valid = busy = (state == SHIFT).
- ser_last = SHIFT & (count == 1).
- remaining = count.
- ser_data:
  - MSB_FIRST = 0: register[LANES-1:0].
  - MSB_FIRST = 1: register[W-1 -: LANES], so ser_data[LANES-1] = register[W-1].
- in_ready = ~abort & (IDLE | (ser_last & ser_ready)). This is combinational and allows zero-bubble reload.
- IDLE, on a load handshake: register <= in_data, count <= N, go to SHIFT. The first beat is presented on the next cycle (one-cycle latency from load to first beat).
- SHIFT, on a beat handshake (ser_valid & ser_ready) with count > 1:
  - MSB_FIRST = 0: register <= {FILL x LANES, register[W-1:LANES]}.
  - MSB_FIRST = 1: register <= {register[W-1-LANES:0], FILL x LANES}.
  - count decrements.
- SHIFT, ser_ready = 0: register, count and outputs hold; ser_data stays stable while ser_valid is high.
- Last beat accepted (count == 1 & ser_ready):
  - done <= 1 for exactly one cycle.
  - With a simultaneous load handshake: register <= in_data, count <= N, stay in SHIFT.
  - Without a load: register shifts as usual, count <= 0, go to IDLE.
- done is also cleared the following cycle unless another last beat is accepted that cycle.
- abort = 1 (synchronous):
  - state <= IDLE, register <= 0, count <= 0, done <= 0.
  - Any in_valid that cycle is ignored (in_ready is forced low).
  - An in-flight word is dropped with no done.
- in_valid in SHIFT is not accepted except on the final accepted beat; in_data is don't-care otherwise.
- Reset asserted mid-word: all state clears immediately, with no done; operation resumes from IDLE after deassertion.
- W == LANES (N = 1): every word is a single beat with ser_last = 1; continuous one beat per cycle under back-to-back load.

Test Plan:
- W=8, LANES=1, MSB_FIRST=0, FILL=1. Load 0xA5, ser_ready = 1 -> ser_data = 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after load. ser_last on beat 8; done pulses 1 cycle after beat 8. Register = 0xFF before its last shift. remaining counts 8..1 then 0.
- W=8, LANES=2, MSB_FIRST=1. Load 0xB4 -> beats 2'b10, 2'b11, 2'b01, 2'b00. Hold ser_ready low for 3 cycles on beat 2 -> 2'b11 stays stable, remaining stays 3, no extra beats.
- Back-to-back: in_valid held high with 0x0F then 0xF0 (W=8, LANES=1, LSB first) -> 16 contiguous beats with no bubble. in_ready is high only in IDLE and on the 8th beat. done pulses twice.
- Abort on beat 3 of 0xA5 -> next cycle IDLE, ser_valid = 0, remaining = 0, no done. A load of 0x3C the same cycle as abort is ignored; a following load of 0x3C serialises normally.
- Reset asserted asynchronously mid-word (between clock edges) -> outputs go to reset values immediately, no done. After release, load 0x01 -> beats 1,0,0,0,0,0,0,0.
- W=4, LANES=4: continuous loads 0x1, 0x2, 0x3 -> ser_data 0x1, 0x2, 0x3 on consecutive cycles, ser_last always 1, done high 3 consecutive cycles.
